rm_decoder: RTL and testbench
=============================

Name: rm_decoder

Overview:
- Decodes the duplicated first-order Reed-Muller RM(1,7) inner code for the HQC decapsulation path. It is the inverse of the RM encoder: it accepts MULTIPLICITY received 128-bit copies of one codeword and returns the 8-bit message byte.
- It sums the copies per position, runs an iterative fast Hadamard transform (FHT), then scans for the largest-magnitude peak.
- It sits between the ciphertext unpacker and the Reed-Solomon decoder.

Parameters:
- MULTIPLICITY, 3: number of 128-bit copies per message byte, 1..7.
- W, 12: signed accumulator/FHT word width; must satisfy W >= clog2(128*MULTIPLICITY)+2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a new decode; honoured only in IDLE.
- cdw_in  input  128  one received codeword copy, in encoder output byte ordering.
- cdw_valid  input  1  cdw_in is valid this cycle.
- cdw_ready  output  1  high in ACCUM; a beat is accepted when cdw_valid && cdw_ready.
- byte_out  output  8  decoded byte; held until the next start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when byte_out is updated.

Behaviour:
- Reset values: byte_out=0x00, done=0, busy=0, cdw_ready=0; state returns to IDLE. Reset is honoured in any state, including mid-ACCUM, mid-FHT and mid-PEAK; no done is generated for an aborted decode.
- Input un-permutation: natural bit vector n[127:0] is built with n[32w+31:32w] = cdw_in[32(3-w)+31:32(3-w)] for w=0..3. This reverses the four 32-bit words; bit order inside each word is unchanged. Position i of n is the evaluation point i.
- Accumulation: a per-position signed value acc[i] (W bits) is cleared on start. Each accepted beat adds +1 if n[i]=0 and -1 if n[i]=1. After MULTIPLICITY beats, acc[i] lies in [-M,+M].
- State IDLE:
  - start -> ACCUM and clear acc.
  - cdw_valid is ignored.
- State ACCUM:
  - cdw_ready=1.
  - A beat counter counts accepted beats; on the MULTIPLICITY-th accepted beat -> FHT.
  - Gaps in cdw_valid are allowed.
  - start is ignored.
- State FHT: 7 cycles, one butterfly stage per cycle.
  - Stage s (0..6) updates every pair (a, a+2^s) with bit s of a equal to 0.
  - The pair is replaced by (x+y, x-y), with all 64 butterflies in parallel.
  - Arithmetic is two's complement in W bits; the W rule guarantees no overflow (|F| <= 128*M).
- State PEAK: 128 cycles, index j=0..127, one entry per cycle.
  - Candidate is replaced only if |F[j]| > best_abs (strict), so ties resolve to the lowest index.
  - best_sign records F[j]<0 for the winning index.
- State DONE: 1 cycle.
  - byte_out[6:0]=best index and byte_out[7]=best_sign; done=1.
  - Next state is IDLE.
- Latency: done is high exactly 136 cycles after the cycle in which the final beat is accepted (7 FHT + 128 PEAK + 1).
- start while busy is ignored; it is not queued.
- A start in the DONE cycle is ignored because the block is not yet in IDLE. Back-to-back throughput is therefore one decode per 137 + MULTIPLICITY cycles minimum.

Optional Feature:
- Macro RM_DEC_PEAK_OUT_EN.
- When defined, adds output port peak_out [W-1:0]. It holds best_abs, unsigned, as the decode reliability metric for soft RS use. It resets to 0 and updates with done.
- When undefined, the port and its register are absent; all other behaviour is identical.

Test Plan:
- Error-free 0x00: start, then 3 beats of cdw_in=128'h0 -> done after 136 cycles, byte_out=0x00, peak_out=384.
- Error-free 0xFF: 3 beats of the RM encoder output for 0xFF -> byte_out=0xFF, peak_out=384. The negative peak must set bit 7.
- Exhaustive: all 256 bytes, each encoded by the RM encoder with 3 identical copies -> byte_out equals the input byte every time, with done exactly once per decode.
- Errors: byte 0xA5, copy 0 with bits 0..19 flipped, copy 1 with bits 64..83 flipped, copy 2 clean -> byte_out=0xA5, peak_out=384-2*40=304.
- Handshake:
  - cdw_valid pulsed with 2-cycle gaps -> exactly 3 beats counted.
  - start pulsed during FHT -> ignored.
  - cdw_valid while in IDLE -> no effect on the result.
- Reset mid-PEAK: rst asserted at cycle 60 of PEAK -> next cycle busy=0, byte_out=0x00, no done. A following clean decode of 0x3C -> byte_out=0x3C.

Source files
------------

// File: rtl/rm_decoder.sv
// Duplicated RM(1,7) decoder: sums MULTIPLICITY copies per position, runs a 7-stage FHT, then
// scans for the largest-magnitude peak. Define RM_DEC_PEAK_OUT_EN to expose the peak magnitude.
module rm_decoder #(
  parameter int unsigned MULTIPLICITY = 3,
  parameter int unsigned W            = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cdw_in,
  input  logic         cdw_valid,
  output logic         cdw_ready,
  output logic [7:0]   byte_out,
  output logic         busy,
`ifdef RM_DEC_PEAK_OUT_EN
  output logic [W-1:0] peak_out,
`endif
  output logic         done
);

  typedef enum logic [2:0] {StIdle, StAccum, StFht, StPeak, StDone} state_e;

  localparam logic signed [W-1:0] One = W'(1);

  state_e state_q, state_d;

  logic signed [W-1:0] acc_q [128];
  logic signed [W-1:0] acc_d [128];
  logic [127:0]        n_vec;
  logic [2:0]          beat_q, stage_q;
  logic [6:0]          idx_q, partner;
  logic                beat_accept, last_beat;

  logic [W-1:0]        best_abs_q, best_abs_n, cur_abs;
  logic                best_sign_q, best_sign_n, cur_neg;
  logic [6:0]          best_idx_q, best_idx_n;
  logic signed [W-1:0] cur;
  logic [7:0]          byte_q;
`ifdef RM_DEC_PEAK_OUT_EN
  logic [W-1:0]        peak_q;
`endif

  // Encoder emits the four 32-bit words in reverse order.
  always_comb begin
    for (int w = 0; w < 4; w++) begin
      n_vec[32*w +: 32] = cdw_in[32*(3-w) +: 32];
    end
  end

  assign beat_accept = (state_q == StAccum) && cdw_valid;
  assign last_beat   = beat_accept && (beat_q == 3'(MULTIPLICITY - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (last_beat) state_d = StFht;
      StFht:   if (stage_q == 3'd6) state_d = StPeak;
      StPeak:  if (idx_q == 7'd127) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != StIdle);
    cdw_ready = (state_q == StAccum);
    done      = (state_q == StDone);
  end

  // Accumulation and in-place butterfly stage
  always_comb begin
    acc_d   = acc_q;
    partner = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < 128; i++) acc_d[i] = '0;
        end
      end
      StAccum: begin
        if (beat_accept) begin
          for (int i = 0; i < 128; i++) begin
            acc_d[i] = n_vec[i] ? acc_q[i] - One : acc_q[i] + One;
          end
        end
      end
      StFht: begin
        for (int i = 0; i < 128; i++) begin
          partner = 7'(i) ^ (7'd1 << stage_q);
          // Lower index of the pair takes x+y, upper takes x-y.
          if (partner > 7'(i)) acc_d[i] = acc_q[i] + acc_q[partner];
          else                 acc_d[i] = acc_q[partner] - acc_q[i];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // Peak candidate for the current scan index; strict compare keeps the lowest index on ties.
  always_comb begin
    cur         = acc_q[idx_q];
    cur_neg     = cur[W-1];
    cur_abs     = cur_neg ? W'(-cur) : W'(cur);
    best_abs_n  = best_abs_q;
    best_sign_n = best_sign_q;
    best_idx_n  = best_idx_q;
    if (cur_abs > best_abs_q) begin
      best_abs_n  = cur_abs;
      best_sign_n = cur_neg;
      best_idx_n  = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q      <= '0;
      stage_q     <= '0;
      idx_q       <= '0;
      best_abs_q  <= '0;
      best_sign_q <= 1'b0;
      best_idx_q  <= '0;
      byte_q      <= '0;
`ifdef RM_DEC_PEAK_OUT_EN
      peak_q      <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            beat_q      <= '0;
            stage_q     <= '0;
            idx_q       <= '0;
            best_abs_q  <= '0;
            best_sign_q <= 1'b0;
            best_idx_q  <= '0;
          end
        end
        StAccum: if (beat_accept) beat_q <= beat_q + 3'd1;
        StFht:   stage_q <= stage_q + 3'd1;
        StPeak: begin
          idx_q       <= idx_q + 7'd1;
          best_abs_q  <= best_abs_n;
          best_sign_q <= best_sign_n;
          best_idx_q  <= best_idx_n;
          if (idx_q == 7'd127) begin
            byte_q <= {best_sign_n, best_idx_n};
`ifdef RM_DEC_PEAK_OUT_EN
            peak_q <= best_abs_n;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign byte_out = byte_q;
`ifdef RM_DEC_PEAK_OUT_EN
  assign peak_out = peak_q;
`endif

endmodule

// File: tb/tb_rm_decoder.sv
// Self-checking bench for rm_decoder: directed cases plus randomized bytes/errors against a
// direct-correlation reference decoder.
module tb_rm_decoder;

  localparam int unsigned M  = 3;
  localparam int unsigned WW = 12;

  logic         clk = 1'b0;
  logic         rst, start, cdw_valid;
  logic [127:0] cdw_in;
  logic         cdw_ready, busy, done;
  logic [7:0]   byte_out;
`ifdef RM_DEC_PEAK_OUT_EN
  logic [WW-1:0] peak_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rm_decoder #(.MULTIPLICITY(M), .W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cdw_in    (cdw_in),
    .cdw_valid (cdw_valid),
    .cdw_ready (cdw_ready),
    .byte_out  (byte_out),
    .busy      (busy),
`ifdef RM_DEC_PEAK_OUT_EN
    .peak_out  (peak_out),
`endif
    .done      (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Evaluation point i carries m[7] ^ <m[6:0], i>; words are emitted in reverse order.
  function automatic logic [127:0] encode(input logic [7:0] m);
    logic [127:0] n, c;
    for (int i = 0; i < 128; i++) n[i] = m[7] ^ (^(m[6:0] & 7'(i)));
    for (int w = 0; w < 4; w++) c[32*(3-w) +: 32] = n[32*w +: 32];
    return c;
  endfunction

  // Maximum-correlation decoding against every affine codeword.
  task automatic ref_model(input logic [127:0] c0, input logic [127:0] c1, input logic [127:0] c2,
                           output logic [7:0] b, output int pk);
    logic [127:0] cp [3];
    int acc [128];
    int f, a, best, bidx, bs;
    cp[0] = c0; cp[1] = c1; cp[2] = c2;
    for (int i = 0; i < 128; i++) acc[i] = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) begin
        acc[i] += cp[k][32*(3-i/32) + i%32] ? -1 : 1;
      end
    end
    best = 0; bidx = 0; bs = 0;
    for (int j = 0; j < 128; j++) begin
      f = 0;
      for (int i = 0; i < 128; i++) f += (^(7'(j) & 7'(i))) ? -acc[i] : acc[i];
      a = (f < 0) ? -f : f;
      if (a > best) begin
        best = a; bidx = j; bs = (f < 0) ? 1 : 0;
      end
    end
    b  = {1'(bs), 7'(bidx)};
    pk = best;
  endtask

  task automatic run_decode(input logic [127:0] c0, input logic [127:0] c1,
                            input logic [127:0] c2, input logic [7:0] exp_b, input int exp_pk,
                            input int gap_max, input bit poke, input string tag);
    logic [127:0] cp [3];
    int cnt, gap;
    cp[0] = c0; cp[1] = c1; cp[2] = c2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cdw_in    = cp[k];
      cdw_valid = 1'b1;
      @(negedge clk);
      cdw_valid = 1'b0;
      cdw_in    = {$urandom, $urandom, $urandom, $urandom};
      if (k < 2) begin
        gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (gap) @(negedge clk);
      end
    end
    cnt = 1;
    while (!done && cnt < 300) begin
      start = poke && (cnt == 3);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({tag, " latency"}, cnt, 136);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " byte"}, 32'(byte_out), 32'(exp_b));
`ifdef RM_DEC_PEAK_OUT_EN
    check({tag, " peak"}, 32'(peak_out), exp_pk);
`endif
    @(negedge clk);
    check({tag, " done width"}, 32'(done), 0);
    check({tag, " idle"}, 32'(busy), 0);
    check({tag, " byte hold"}, 32'(byte_out), 32'(exp_b));
  endtask

  initial begin
    logic [127:0] c0, c1, c2, mask;
    logic [7:0]   eb;
    int           ep, cnt, ndone;

    rst = 1'b1; start = 1'b0; cdw_valid = 1'b0; cdw_in = '0;
    repeat (3) @(negedge clk);
    check("reset byte", 32'(byte_out), 0);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset ready", 32'(cdw_ready), 0);
`ifdef RM_DEC_PEAK_OUT_EN
    check("reset peak", 32'(peak_out), 0);
`endif
    rst = 1'b0;

    // cdw_valid in IDLE must not leak into the next decode.
    cdw_valid = 1'b1; cdw_in = {128{1'b1}};
    repeat (4) @(negedge clk);
    check("idle ready", 32'(cdw_ready), 0);
    check("idle busy", 32'(busy), 0);
    cdw_valid = 1'b0;

    run_decode(128'h0, 128'h0, 128'h0, 8'h00, 384, 0, 1'b0, "zero");
    c0 = encode(8'hFF);
    run_decode(c0, c0, c0, 8'hFF, 384, 0, 1'b0, "ff");

    c0   = encode(8'hA5);
    mask = (128'h1 << 20) - 128'h1;
    run_decode(c0 ^ mask, c0 ^ (mask << 64), c0, 8'hA5, 304, 0, 1'b0, "err a5");

    c0 = encode(8'h5A);
    run_decode(c0, c0, c0, 8'h5A, 384, 2, 1'b1, "gap poke");

    for (int b = 0; b < 256; b++) begin
      c0 = encode(8'(b));
      ref_model(c0, c0, c0, eb, ep);
      check("model exh", 32'(eb), 32'(b));
      run_decode(c0, c0, c0, eb, ep, $urandom_range(0, 2), 1'($urandom_range(0, 1)), "exh");
    end

    for (int t = 0; t < 24; t++) begin
      c0 = encode(8'($urandom));
      c1 = c0; c2 = c0;
      repeat ($urandom_range(0, 30)) c0[$urandom_range(0, 127)] ^= 1'b1;
      repeat ($urandom_range(0, 30)) c1[$urandom_range(0, 127)] ^= 1'b1;
      repeat ($urandom_range(0, 30)) c2[$urandom_range(0, 127)] ^= 1'b1;
      ref_model(c0, c1, c2, eb, ep);
      run_decode(c0, c1, c2, eb, ep, 3, 1'b0, "rand err");
    end

    // Abort mid-PEAK, then confirm no stray done and a clean follow-up decode.
    c0 = encode(8'hC3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cdw_in = c0; cdw_valid = 1'b1;
      @(negedge clk);
    end
    cdw_valid = 1'b0;
    repeat (66) @(negedge clk);
    check("pre abort busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 0);
    check("abort byte", 32'(byte_out), 0);
    check("abort done", 32'(done), 0);
    ndone = 0;
    for (cnt = 0; cnt < 150; cnt++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort no done", ndone, 0);
    c0 = encode(8'h3C);
    run_decode(c0, c0, c0, 8'h3C, 384, 1, 1'b0, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
